// File: rtl/scsi_bus_arbiter.sv
// Bus-ownership sequencer for the 53C710 DMA master path: hands the host bus to the chip.
// Optional tenure-limit flag enabled by defining ARB_TENURE_LIMIT_EN.
module scsi_bus_arbiter #(
    parameter int unsigned HOLDOFF     = 4,
    parameter int unsigned ACK_TIMEOUT = 15,
    parameter int unsigned MAX_TENURE  = 256,
    parameter int unsigned CNT_W       = 9
) (
    input  logic       CLK,
    input  logic       IORST_n,
    input  logic       SBR_n,
    input  logic       SBGACK_n,
    output logic       SBG_n,
    output logic       EBR_n,
    input  logic       EBG_n,
    output logic       EBGACK_n,
    input  logic       slave_cycle,
    output logic       MYBUS_n,
    output logic       tenure_expired,
    output logic [2:0] arb_state
);

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StReq     = 3'd1,
        StGrant   = 3'd2,
        StOwned   = 3'd3,
        StRelease = 3'd4
    } arb_state_e;

    localparam longint unsigned CntRange   = 64'd1 << CNT_W;
    localparam logic [CNT_W-1:0] Holdoff    = CNT_W'(HOLDOFF);
    localparam logic [CNT_W-1:0] AckTimeout = CNT_W'(ACK_TIMEOUT);
    localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);

    if (HOLDOFF >= CntRange || ACK_TIMEOUT >= CntRange || MAX_TENURE >= CntRange) begin : g_bad_cnt_w
        $error("scsi_bus_arbiter: CNT_W too narrow for counter limits");
    end

    arb_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ebg_meta_q;
    logic             ebg_s_q;

`ifdef ARB_TENURE_LIMIT_EN
    localparam logic [CNT_W-1:0] MaxTenure = CNT_W'(MAX_TENURE);
    logic tenure_q;
    assign tenure_expired = tenure_q;
`else
    assign tenure_expired = 1'b0;
`endif

    assign arb_state = state_q;

    always_ff @(posedge CLK or negedge IORST_n) begin
        if (!IORST_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            ebg_meta_q <= 1'b1;
            ebg_s_q    <= 1'b1;
            SBG_n      <= 1'b1;
            EBR_n      <= 1'b1;
            EBGACK_n   <= 1'b1;
            MYBUS_n    <= 1'b1;
`ifdef ARB_TENURE_LIMIT_EN
            tenure_q   <= 1'b0;
`endif
        end else begin
            ebg_meta_q <= EBG_n;
            ebg_s_q    <= ebg_meta_q;
            case (state_q)
                StIdle: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CntOne;
                    end
                    // A CPU slave access in flight always beats a new DMA request.
                    if (!SBR_n && !slave_cycle && cnt_q == '0) begin
                        state_q <= StReq;
                        EBR_n   <= 1'b0;
                    end
                end
                StReq: begin
                    if (SBR_n) begin
                        state_q <= StIdle;
                        EBR_n   <= 1'b1;
                    end else if (!ebg_s_q) begin
                        state_q  <= StGrant;
                        EBGACK_n <= 1'b0;
                        MYBUS_n  <= 1'b0;
                        SBG_n    <= 1'b0;
                        EBR_n    <= 1'b1;
                        cnt_q    <= '0;
                    end
                end
                StGrant: begin
                    cnt_q <= cnt_q + CntOne;
                    if (!SBGACK_n) begin
                        state_q <= StOwned;
                        SBG_n   <= 1'b1;
                        cnt_q   <= '0;
                    end else if (cnt_q == AckTimeout) begin
                        state_q <= StRelease;
                    end
                end
                StOwned: begin
                    if (cnt_q != '1) begin
                        cnt_q <= cnt_q + CntOne;
                    end
`ifdef ARB_TENURE_LIMIT_EN
                    if (cnt_q == MaxTenure) begin
                        tenure_q <= 1'b1;
                    end
`endif
                    if (SBGACK_n) begin
                        state_q <= StRelease;
                    end
                end
                StRelease: begin
                    state_q  <= StIdle;
                    EBGACK_n <= 1'b1;
                    MYBUS_n  <= 1'b1;
                    SBG_n    <= 1'b1;
                    cnt_q    <= Holdoff;
`ifdef ARB_TENURE_LIMIT_EN
                    tenure_q <= 1'b0;
`endif
                end
                default: begin
                    state_q <= StRelease;
                end
            endcase
        end
    end

endmodule
